// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame-format encodings and the
// parity helper used by the configurable transmitter (and later the receiver).
package uart_pkg;

    // Transmitter FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // parity_mode encodings (2'b11 is treated as none)
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // stop_mode encodings (2'b11 is treated as two stop bits)
    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // Widest data word the parity helper accepts
    localparam int PAR_MAX_BITS = 16;

    // XOR of the low len bits of data, inverted when odd parity is requested
    function automatic logic calc_parity(
        input logic [PAR_MAX_BITS-1:0] data,
        input int unsigned             len,
        input logic                    odd
    );
        logic p;
        p = odd;
        for (int unsigned i = 0; i < PAR_MAX_BITS; i++) begin
            if (i < len) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, 1..DBIT data bits LSB
// first, optional even/odd parity, then 1, 1.5 or 2 stop bits. Paced by an
// external oversampling tick; the frame format is captured when a frame is
// accepted so the inputs may change freely while it is on the line.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OVS  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_tick,
    input  logic                      tx_start,
    input  logic [DBIT-1:0]           tx_din,
    input  logic [$clog2(DBIT+1)-1:0] data_len,
    input  logic [1:0]                parity_mode,
    input  logic [1:0]                stop_mode,
    output logic                      tx_ready,
    output logic                      tx_done_tick,
    output logic                      tx
);

    localparam int LW = $clog2(DBIT+1);
    localparam int TW = $clog2(2*OVS);
    localparam int BW = $clog2(DBIT);

    // Last tick index of each timed period
    localparam logic [TW-1:0] BIT_LAST   = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP1_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'((3*OVS)/2 - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2*OVS - 1);

    logic [2:0]      state_reg, state_next;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [BW-1:0]   bit_reg, bit_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic [LW-1:0]   len_reg, len_next;
    logic            par_reg, par_next;
    logic            par_en_reg, par_en_next;
    logic [1:0]      stop_mode_reg, stop_mode_next;
    logic            tx_reg, tx_next;

    // Out-of-range lengths (0 or above DBIT) fall back to a full DBIT word
    logic [LW-1:0]              len_norm;
    logic [PAR_MAX_BITS-1:0]    data_ext;
    logic [TW-1:0]              stop_last;
    logic                       last_bit;

    // Normalise the requested format and derive per-frame comparison values
    always_comb begin
        len_norm = data_len;
        if (data_len == '0 || data_len > LW'(DBIT)) begin
            len_norm = LW'(DBIT);
        end
        data_ext = PAR_MAX_BITS'(tx_din);
        case (stop_mode_reg)
            STOP_1:   stop_last = STOP1_LAST;
            STOP_1P5: stop_last = STOP15_LAST;
            default:  stop_last = STOP2_LAST;
        endcase
        last_bit = (LW'(bit_reg) == len_reg - LW'(1));
    end

    // All state registers; reset forces an idle, high line immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            tick_reg      <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            len_reg       <= '0;
            par_reg       <= 1'b0;
            par_en_reg    <= 1'b0;
            stop_mode_reg <= '0;
            tx_reg        <= 1'b1;
        end else begin
            state_reg     <= state_next;
            tick_reg      <= tick_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            len_reg       <= len_next;
            par_reg       <= par_next;
            par_en_reg    <= par_en_next;
            stop_mode_reg <= stop_mode_next;
            tx_reg        <= tx_next;
        end
    end

    // Frame sequencing: counters move only on s_tick
    always_comb begin
        state_next     = state_reg;
        tick_next      = tick_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        len_next       = len_reg;
        par_next       = par_reg;
        par_en_next    = par_en_reg;
        stop_mode_next = stop_mode_reg;
        tx_next        = 1'b1;
        tx_done_tick   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    shift_next     = tx_din;
                    len_next       = len_norm;
                    par_next       = calc_parity(data_ext, 32'(len_norm),
                                                 parity_mode == PAR_ODD);
                    par_en_next    = (parity_mode == PAR_EVEN) ||
                                     (parity_mode == PAR_ODD);
                    stop_mode_next = stop_mode;
                    tick_next      = '0;
                    state_next     = ST_START;
                end
            end

            ST_START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = ST_DATA;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end

            ST_DATA: begin
                tx_next = shift_reg[0];
                if (s_tick) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next  = '0;
                        shift_next = shift_reg >> 1;
                        if (last_bit) begin
                            state_next = par_en_reg ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_next = bit_reg + BW'(1);
                        end
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end

            ST_PARITY: begin
                tx_next = par_reg;
                if (s_tick) begin
                    if (tick_reg == BIT_LAST) begin
                        tick_next  = '0;
                        state_next = ST_STOP;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end

            ST_STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (tick_reg == stop_last) begin
                        tick_next    = '0;
                        tx_done_tick = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
            end

            default: begin
                tx_next    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = (state_reg == ST_IDLE);
    assign tx       = tx_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg. Each frame is expanded by a reference
// model into the expected line level for every s_tick of the frame; the line
// is sampled in the cycle carrying each tick and compared against it.
module tb_uart_tx_cfg;

    localparam int DBIT = 8;
    localparam int OVS  = 16;
    localparam int LW   = $clog2(DBIT+1);

    logic            clk = 1'b0;
    logic            reset;
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] tx_din;
    logic [LW-1:0]   data_len;
    logic [1:0]      parity_mode;
    logic [1:0]      stop_mode;
    logic            tx_ready;
    logic            tx_done_tick;
    logic            tx;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected line level, one entry per s_tick of the current frame
    bit exp_q[$];

    uart_tx_cfg #(.DBIT(DBIT), .OVS(OVS)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .data_len     (data_len),
        .parity_mode  (parity_mode),
        .stop_mode    (stop_mode),
        .tx_ready     (tx_ready),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference frame: start, len data bits LSB first, optional parity, stop
    function automatic void build(input logic [DBIT-1:0] d, input int dl,
                                  input int pm, input int sm);
        int len;
        int st;
        bit p;
        len = (dl == 0 || dl > DBIT) ? DBIT : dl;
        p = 1'b0;
        exp_q.delete();
        repeat (OVS) exp_q.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            p = p ^ d[i];
            repeat (OVS) exp_q.push_back(d[i]);
        end
        if (pm == 1 || pm == 2) begin
            if (pm == 2) p = ~p;
            repeat (OVS) exp_q.push_back(p);
        end
        st = (sm == 0) ? OVS : (sm == 1) ? (3*OVS)/2 : 2*OVS;
        repeat (st) exp_q.push_back(1'b1);
    endfunction

    // Send one frame and check it tick by tick. With disturb set, the config
    // inputs are scrambled mid-frame and tx_start is pulsed mid-DATA and in
    // the tx_done_tick cycle; none of that may alter or restart the frame.
    // abort_at >= 0 asserts reset just before that tick instead of finishing.
    task automatic run_frame(input string name, input logic [DBIT-1:0] d,
                             input int dl, input int pm, input int sm,
                             input bit disturb, input int abort_at);
        int n;
        build(d, dl, pm, sm);
        n = exp_q.size();
        $display("frame %s: data=%h len=%0d par=%0d stop=%0d ticks=%0d",
                 name, d, dl, pm, sm, n);
        @(negedge clk);
        tx_din = d; data_len = LW'(dl); parity_mode = 2'(pm);
        stop_mode = 2'(sm); tx_start = 1'b1; s_tick = 1'b0;
        @(negedge clk);
        tx_start = 1'b0;
        #1 chk({name, ".busy"}, tx_ready, 1'b0);
        for (int j = 0; j < n; j++) begin
            repeat (3) begin
                @(negedge clk);
                s_tick = 1'b0;
                if (disturb) begin
                    tx_din = DBIT'($urandom); data_len = LW'($urandom);
                    parity_mode = 2'($urandom); stop_mode = 2'($urandom);
                    tx_start = (j == 40);
                end
            end
            if (j == abort_at) begin
                @(negedge clk);
                reset = 1'b1;
                #1;
                chk({name, ".rst_tx"}, tx, 1'b1);
                chk({name, ".rst_ready"}, tx_ready, 1'b1);
                chk({name, ".rst_done"}, tx_done_tick, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            s_tick = 1'b1;
            tx_start = disturb && (j == n-1);
            #1;
            chk($sformatf("%s.tx%0d", name, j), tx, exp_q[j]);
            chk($sformatf("%s.done%0d", name, j), tx_done_tick, j == n-1);
        end
        @(negedge clk);
        s_tick = 1'b0; tx_start = 1'b0;
        #1;
        chk({name, ".ready_after"}, tx_ready, 1'b1);
        chk({name, ".tx_after"}, tx, 1'b1);
        chk({name, ".done_after"}, tx_done_tick, 1'b0);
        if (disturb) begin
            // No frame may have been queued by the ignored requests
            for (int k = 0; k < 6; k++) begin
                repeat (3) @(negedge clk);
                s_tick = 1'b1;
                @(negedge clk);
                s_tick = 1'b0;
                #1;
                chk($sformatf("%s.idle_tx%0d", name, k), tx, 1'b1);
                chk($sformatf("%s.idle_ready%0d", name, k), tx_ready, 1'b1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; s_tick = 1'b0; tx_start = 1'b0;
        tx_din = '0; data_len = '0; parity_mode = 2'b00; stop_mode = 2'b00;
        @(negedge clk);
        #1;
        chk("reset.tx", tx, 1'b1);
        chk("reset.ready", tx_ready, 1'b1);
        chk("reset.done", tx_done_tick, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("8N1_A5", 8'hA5, 8, 0, 0, 1'b0, -1);
        run_frame("7E2_41", 8'h41, 7, 1, 2, 1'b0, -1);
        run_frame("5O15_1F", 8'h1F, 5, 2, 1, 1'b0, -1);
        run_frame("5O15_0F", 8'h0F, 5, 2, 1, 1'b0, -1);
        run_frame("disturb", 8'h3C, 6, 1, 0, 1'b1, -1);
        run_frame("len0", 8'hC3, 0, 3, 3, 1'b0, -1);
        run_frame("len_over", 8'h96, 12, 2, 0, 1'b0, -1);
        // Reset during data bit 3 (tick index 16 + 3*16 + 5)
        run_frame("abort", 8'h5A, 8, 1, 0, 1'b0, OVS + 3*OVS + 5);
        run_frame("after_abort", 8'h5A, 8, 1, 0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            run_frame($sformatf("rand%0d", r), DBIT'($urandom),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), r[0], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
